mult_shift_add: RTL and testbench
=================================

# mult_shift_add

Sequential unsigned multiplier that reuses one `width`-bit ripple-carry adder over `width` iterations instead of building a full array multiplier. It sits between the calculator's operand registers and result mux. It accepts one operand pair per transaction through a valid/ready handshake and returns a `2*width`-bit product through a second valid/ready handshake.

## Interface
- `width`, default 8, operand width in bits; legal range ≥ 2
- `clk_i`  input  1  clock; all state changes on the rising edge
- `rst_ni`  input  1  reset; asynchronous, active-low
- `valid_i`  input  1  operand pair on `a_i`/`b_i` is valid
- `ready_o`  output  1  block can accept an operand pair
- `a_i`  input  `width`  multiplicand, unsigned
- `b_i`  input  `width`  multiplier, unsigned
- `valid_o`  output  1  `p_o` holds a finished product
- `ready_i`  input  1  consumer accepts the product
- `p_o`  output  `2*width`  product `a_i*b_i`, unsigned

## Operation
- FSM states:
  - IDLE: `ready_o`=1.
  - RUN: iterating.
  - DONE: `valid_o`=1.
- IDLE → RUN on `valid_i && ready_o`. At this edge:
  - `mcand` ← `a_i`
  - `lo` ← `b_i`
  - `hi` ← 0
  - `cnt` ← 0
- `a_i`/`b_i` are sampled only at acceptance and ignored afterwards.
- RUN, each cycle:
  - Adder operands are `hi` and (`lo[0]` ? `mcand` : 0), giving `{c, s}`.
  - Update `{hi, lo}` ← `{c, s, lo[width-1:1]}`, a `2*width`-bit right shift that keeps the carry.
  - `cnt` ← `cnt+1`.
- RUN → DONE on the edge where `cnt == width-1`, which completes exactly `width` iterations.
- DONE:
  - `p_o` = `{hi, lo}`; this value is final.
  - `valid_o`=1. `p_o` and `valid_o` stay stable while `ready_i`=0.
- DONE → IDLE on `ready_i`=1. `p_o` keeps the last product until the next result.
- `valid_i` during RUN or DONE is ignored because `ready_o`=0. There is no queuing.
- Width rules:
  - The product never overflows `2*width` bits.
  - The adder carry-out is always absorbed into `hi` via the shift.
  - `cnt` width is `$clog2(width)`, with a minimum of 1.
- Reset (`rst_ni`=0), at any time including mid-RUN or DONE:
  - State goes to IDLE immediately, asynchronously.
  - `mcand`, `hi`, `lo`, `cnt` clear to 0. An in-flight transaction is discarded with no `valid_o` pulse.
- Reset values: `ready_o`=1, `valid_o`=0, `p_o`=0.

## Timing
- Acceptance edge E0 is the edge where `valid_i && ready_o`.
- Iterations occur on edges E1..E`width`. `valid_o` rises after E`width`, so latency from acceptance is `width` cycles.
- If `ready_i`=1 while `valid_o`=1, the handshake completes at E`width+1` and `ready_o` returns to 1 after that edge.
- Earliest next acceptance is E`width+2`. Throughput is one product per `width+2` cycles with no backpressure.
- `ready_o` and `valid_o` are decoded from the state register only. There is no combinational path from `valid_i` or `ready_i` to any output.
- The adder is purely combinational. The critical path is the `width`-bit ripple chain plus the operand mux into `hi`.

## Structure
- The shared package `calc_pkg` holds `typedef enum logic [1:0] {IDLE, RUN, DONE} mult_state_t`. The same package already serves other calculator sequencers.
- One sub-module: instantiate the team's `full_adder_nbits` with its `width` parameter. It takes `a_i` = `hi` and `b_i` = the gated multiplicand, producing `s_o` and `cout_o`.
- Everything else is local logic: FSM, counter, operand gating and shift register.

## Test plan
- Reset then `valid_i`=1 with `a_i`=0, `b_i`=0 → after 8 cycles `valid_o`=1 and `p_o`=0x0000.
- `a_i`=13, `b_i`=11 with `ready_i` held at 1:
  - `valid_o` rises exactly 8 cycles after acceptance, with `p_o`=143.
  - `ready_o` is back to 1 one cycle later.
- `a_i`=255, `b_i`=255 → `p_o`=0xFE01, confirming the carry is kept on every iteration.
- `ready_i`=0 for 5 cycles after `valid_o` rises:
  - `p_o` and `valid_o` stay stable throughout.
  - A new `valid_i` with `a_i`=3, `b_i`=3 during this window is not accepted.
  - Once `ready_i`=1, the first product is consumed and the second transaction is accepted afterwards, yielding 9.
- Assert `rst_ni`=0 for 1 cycle at iteration 4 of 7×9:
  - Asynchronous return to IDLE with `valid_o`=0, `p_o`=0 and no spurious `valid_o` pulse.
  - A following 7×9 gives 63.
- `width`=4: `a_i`=15, `b_i`=15 → `p_o`=225 after 4 cycles. Also run random operands against a reference model for `width`=4 and `width`=8.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared calculator package: sequencer state encodings used across the datapath blocks.
package calc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_t;

endpackage

// File: rtl/mult_shift_add_if.sv
// Operand/product handshake bundle for the shift-and-add multiplier.
interface mult_shift_add_if #(
    parameter int unsigned width = 8
);
    logic               valid_i;
    logic               ready_o;
    logic [width-1:0]   a_i;
    logic [width-1:0]   b_i;
    logic               valid_o;
    logic               ready_i;
    logic [2*width-1:0] p_o;

    modport master (
        output valid_i, a_i, b_i, ready_i,
        input  ready_o, valid_o, p_o
    );

    modport slave (
        input  valid_i, a_i, b_i, ready_i,
        output ready_o, valid_o, p_o
    );
endinterface

// File: rtl/full_adder_nbits.sv
// Plain ripple-carry adder, no carry-in; carry-out exposed for the caller.
module full_adder_nbits #(
    parameter int unsigned width = 8
) (
    input  logic [width-1:0] a_i,
    input  logic [width-1:0] b_i,
    output logic [width-1:0] s_o,
    output logic             cout_o
);
    logic c;

    always_comb begin
        c   = 1'b0;
        s_o = '0;
        for (int i = 0; i < int'(width); i++) begin
            s_o[i] = a_i[i] ^ b_i[i] ^ c;
            c      = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
        end
        cout_o = c;
    end
endmodule

// File: rtl/mult_shift_add.sv
// Sequential unsigned multiplier: one shared adder, width iterations of add-then-shift.
module mult_shift_add
    import calc_pkg::*;
#(
    parameter int unsigned width = 8
) (
    input logic               clk_i,
    input logic               rst_ni,
    mult_shift_add_if.slave   bus
);
    localparam int unsigned CntW = ($clog2(width) < 1) ? 1 : $clog2(width);
    localparam logic [CntW-1:0] CntLast = CntW'(width - 1);

    mult_state_t        state_q, state_d;
    logic [width-1:0]   mcand_q, mcand_d;
    logic [width-1:0]   hi_q, hi_d;
    logic [width-1:0]   lo_q, lo_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [2*width-1:0] p_q, p_d;

    logic [width-1:0]   addend;
    logic [width-1:0]   sum;
    logic               carry;
    logic [2*width-1:0] shifted;

    assign addend = lo_q[0] ? mcand_q : '0;

    full_adder_nbits #(
        .width (width)
    ) u_adder (
        .a_i    (hi_q),
        .b_i    (addend),
        .s_o    (sum),
        .cout_o (carry)
    );

    // Carry becomes the new MSB, so the partial product never loses a bit.
    assign shifted = {carry, sum, lo_q[width-1:1]};

    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        unique case (state_q)
            IDLE: begin
                if (bus.valid_i) begin
                    state_d = RUN;
                    mcand_d = bus.a_i;
                    lo_d    = bus.b_i;
                    hi_d    = '0;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                {hi_d, lo_d} = shifted;
                cnt_d        = cnt_q + CntW'(1);
                if (cnt_q == CntLast) begin
                    state_d = DONE;
                    p_d     = shifted;
                end
            end
            DONE: begin
                if (bus.ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            mcand_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
        end
    end

    // Product is held in its own register so it stays put until the next result lands.
    assign bus.ready_o = (state_q == IDLE);
    assign bus.valid_o = (state_q == DONE);
    assign bus.p_o     = p_q;
endmodule

// File: tb/tb_mult_shift_add.sv
// Bench for mult_shift_add at width 8 and width 4, checked against integer multiplication.
module tb_mult_shift_add;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    mult_shift_add_if #(.width(8)) bus8 ();
    mult_shift_add_if #(.width(4)) bus4 ();

    mult_shift_add #(.width(8)) u_dut8 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus8.slave)
    );

    mult_shift_add #(.width(4)) u_dut4 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus4.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int w, input logic v, input int a, input int b);
        if (w == 8) begin
            bus8.valid_i = v;
            bus8.a_i     = a[7:0];
            bus8.b_i     = b[7:0];
        end else begin
            bus4.valid_i = v;
            bus4.a_i     = a[3:0];
            bus4.b_i     = b[3:0];
        end
    endtask

    task automatic set_ready(input int w, input logic r);
        if (w == 8) bus8.ready_i = r;
        else        bus4.ready_i = r;
    endtask

    function automatic logic rd_valid(input int w);
        return (w == 8) ? bus8.valid_o : bus4.valid_o;
    endfunction

    function automatic logic rd_ready(input int w);
        return (w == 8) ? bus8.ready_o : bus4.ready_o;
    endfunction

    function automatic logic [15:0] rd_p(input int w);
        return (w == 8) ? bus8.p_o : {8'h00, bus4.p_o};
    endfunction

    // One transaction; stall = cycles of ready_i=0 after valid_o, pend = offer 3x3 while stalled.
    task automatic txn(input int w, input int a_in, input int b_in, input int stall,
                       input bit pend);
        int mask;
        int a;
        int b;
        int exp;
        int lat;
        int n;
        mask = (1 << w) - 1;
        a    = a_in & mask;
        b    = b_in & mask;
        exp  = a * b;
        n = 0;
        while (!rd_ready(w) && n < 50) begin
            step();
            n++;
        end
        check("ready_before_accept", 32'(rd_ready(w)), 32'd1);
        drive(w, 1'b1, a, b);
        set_ready(w, stall == 0);
        step();
        drive(w, 1'b0, int'($urandom), int'($urandom));
        lat = 0;
        while (!rd_valid(w) && lat < 100) begin
            step();
            lat++;
        end
        check("latency", 32'(lat), 32'(w));
        check("product", 32'(rd_p(w)), 32'(exp));
        for (int i = 0; i < stall; i++) begin
            if (pend) drive(w, 1'b1, 3, 3);
            check("stall_valid", 32'(rd_valid(w)), 32'd1);
            check("stall_product", 32'(rd_p(w)), 32'(exp));
            check("stall_ready_low", 32'(rd_ready(w)), 32'd0);
            step();
        end
        if (stall > 0) begin
            check("stall_end_valid", 32'(rd_valid(w)), 32'd1);
            check("stall_end_product", 32'(rd_p(w)), 32'(exp));
        end
        set_ready(w, 1'b1);
        step();
        check("valid_drop", 32'(rd_valid(w)), 32'd0);
        check("ready_back", 32'(rd_ready(w)), 32'd1);
        check("product_held", 32'(rd_p(w)), 32'(exp));
        set_ready(w, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(8, 1'b0, 0, 0);
        drive(4, 1'b0, 0, 0);
        set_ready(8, 1'b0);
        set_ready(4, 1'b0);
        repeat (3) step();
        check("rst_ready8", 32'(bus8.ready_o), 32'd1);
        check("rst_valid8", 32'(bus8.valid_o), 32'd0);
        check("rst_p8", 32'(bus8.p_o), 32'd0);
        check("rst_ready4", 32'(bus4.ready_o), 32'd1);
        check("rst_valid4", 32'(bus4.valid_o), 32'd0);
        check("rst_p4", 32'(bus4.p_o), 32'd0);
        rst_n = 1'b1;
        step();

        txn(8, 0, 0, 0, 1'b0);
        txn(8, 13, 11, 0, 1'b0);
        txn(8, 255, 255, 0, 1'b0);
        txn(8, 200, 100, 5, 1'b1);
        txn(8, 3, 3, 0, 1'b0);

        // Reset in the middle of 7x9, then confirm no stray result appears.
        drive(8, 1'b1, 7, 9);
        set_ready(8, 1'b1);
        step();
        drive(8, 1'b0, 0, 0);
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(bus8.valid_o), 32'd0);
        check("async_rst_ready", 32'(bus8.ready_o), 32'd1);
        check("async_rst_p", 32'(bus8.p_o), 32'd0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (bus8.valid_o) check("spurious_valid", 32'(bus8.valid_o), 32'd0);
            step();
        end
        check("post_rst_valid", 32'(bus8.valid_o), 32'd0);
        set_ready(8, 1'b0);
        txn(8, 7, 9, 0, 1'b0);

        txn(4, 15, 15, 0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            txn(8, int'($urandom), int'($urandom), int'($urandom_range(0, 2)), 1'b0);
            txn(4, int'($urandom), int'($urandom), int'($urandom_range(0, 2)), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
